cu_multicycle: RTL
==================

# cu_multicycle

Multi-cycle control unit for the MIPS datapath. It generalises the single-cycle opcode decoder into a Moore/Mealy FSM that sequences instruction fetch, decode, execute, memory and write-back over several clocks. It stalls on a shared memory ready handshake and flags illegal opcodes. It sits between the instruction register (opcode source) and the multi-cycle datapath muxes, register file, ALU control and unified memory.

## Interface
- `OPCODE_W`, default 6: opcode width.
- `ALU_OP_W`, default 2: ALU-control op width, must be ≥2; the upper bits are always 0.
- `clk` in, 1 bit: the single clock. One clock; all state changes on rising edge.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `opcode` in, `OPCODE_W` bits: instruction[31:26] from IR, sampled in DECODE.
- `mem_ready` in, 1 bit: memory has completed the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` out, 1 bit each: datapath controls.
- `alu_src_b` out, 2 bits: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out, `ALU_OP_W` bits: 00 = add, 01 = sub, 10 = use funct.
- `pc_source` out, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out, 1 bit: one-cycle pulse in the final state of each instruction.
- `illegal_op` out, 1 bit: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
- Outputs are decoded from the state register. Every output not listed for a state is 0.
- IDLE
  - All outputs are 0.
  - Next state is always FETCH.
- FETCH
  - Asserts `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` = `mem_ready` (Mealy-qualified).
  - Stays in FETCH while `mem_ready`=0; goes to DECODE otherwise.
- DECODE
  - Asserts `alu_src_b`=11, `alu_op`=00.
  - Dispatch by opcode:
    - 100011 or 101011 → MEM_ADDR.
    - 000000 → EXECUTE.
    - 001000 → ADDI_EX.
    - 000100 → BRANCH.
    - 000010 → JUMP (only when the jump macro is defined).
    - Any other opcode: `illegal_op`=1 and next state FETCH. No register or memory side effects.
- MEM_ADDR
  - Asserts `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ
  - Asserts `mem_read`, `i_or_d`=1.
  - Holds while `mem_ready`=0, then goes to MEM_WB.
- MEM_WB
  - Asserts `reg_write`, `mem_to_reg`, `reg_dst`=0, `instr_done`.
  - Next state FETCH.
- MEM_WRITE
  - Asserts `mem_write`, `i_or_d`=1.
  - Holds while `mem_ready`=0.
  - `instr_done` = `mem_ready`; goes to FETCH on `mem_ready`.
- EXECUTE
  - Asserts `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - Next state R_WB.
- R_WB
  - Asserts `reg_dst`=1, `reg_write`, `instr_done`.
  - Next state FETCH.
- ADDI_EX
  - Asserts `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state ADDI_WB.
- ADDI_WB
  - Asserts `reg_dst`=0, `reg_write`, `instr_done`.
  - Next state FETCH.
- BRANCH
  - Asserts `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01, `instr_done`.
  - Next state FETCH.
- JUMP
  - Asserts `pc_write`, `pc_source`=10, `instr_done`.
  - Next state FETCH.

## Timing
- Reset
  - `rst_n` low forces the state to IDLE immediately, mid-instruction included. All outputs go to 0 in the same delta.
  - An in-flight memory access is abandoned.
  - On the first edge after `rst_n` rises, the state moves to FETCH.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Illegal opcode: 2.
- Each `mem_ready`=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs are held stable throughout the stall.
- `opcode` only needs to be valid during DECODE; it is ignored in every other state.
- `instr_done` and `illegal_op` are never asserted in the same cycle.

## Configuration
- `CU_JUMP_EN` defined: opcode 000010 dispatches to JUMP.
- `CU_JUMP_EN` undefined: the JUMP state and the `pc_source`=10 encoding are not generated. Opcode 000010 takes the illegal path: `illegal_op` pulses and the FSM returns to FETCH.

## Structure
- Shared package `cu_pkg` holds:
  - the state enum;
  - the opcode constants (R_TYPE, LW, SW, BEQ, ADDI, J);
  - the ALU op encodings (ALU_ADD, ALU_SUB, ALU_FUNCT);
  - the `alu_src_b` and `pc_source` encodings.
- One sub-module, `cu_out_decode`: purely combinational mapping from (state, `mem_ready`) to the control word. The top level owns the state register and the next-state logic.

## Test plan
- Reset, then `rst_n` release with `mem_ready`=1, lw (100011):
  - IDLE→FETCH→DECODE→MEM_ADDR→MEM_READ→MEM_WB.
  - `reg_write`=1 and `mem_to_reg`=1 only in cycle 5 of the instruction; `instr_done` pulses once.
- sw (101011) with `mem_ready` low for 3 cycles in MEM_WRITE:
  - `mem_write`=1 for 4 cycles, `instr_done` on the 4th.
  - `reg_write` never asserted.
- R-type (000000): `alu_op`=10 in EXECUTE; `reg_dst`=1 and `reg_write`=1 in R_WB; 4 cycles total.
- beq (000100): `pc_write_cond`=1, `alu_op`=01, `pc_source`=01 in cycle 3; next cycle is FETCH.
- Opcode 000010:
  - With `CU_JUMP_EN`: `pc_write`=1 and `pc_source`=10 in cycle 3.
  - Without it: `illegal_op` pulses in DECODE, then FETCH.
  - Opcode 111111 always pulses `illegal_op`.
- `rst_n` asserted during MEM_READ: outputs go to 0 immediately; after release, the FSM passes IDLE then FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// The JUMP state and the jump-target pc_source encoding exist only when CU_JUMP_EN is defined.
package cu_pkg;

  // FSM state encoding
  typedef logic [3:0] state_t;

  localparam state_t StIdle     = 4'd0;
  localparam state_t StFetch    = 4'd1;
  localparam state_t StDecode   = 4'd2;
  localparam state_t StMemAddr  = 4'd3;
  localparam state_t StMemRead  = 4'd4;
  localparam state_t StMemWb    = 4'd5;
  localparam state_t StMemWrite = 4'd6;
  localparam state_t StExecute  = 4'd7;
  localparam state_t StRWb      = 4'd8;
  localparam state_t StAddiEx   = 4'd9;
  localparam state_t StAddiWb   = 4'd10;
  localparam state_t StBranch   = 4'd11;
`ifdef CU_JUMP_EN
  localparam state_t StJump     = 4'd12;
`endif

  // Opcodes (instruction[31:26])
  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] J      = 6'b000010;

  // ALU-control op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_SHIFT = 2'b11;

  // pc_source selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
`ifdef CU_JUMP_EN
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
`endif

  // Control word driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/cu_out_decode.sv
// Combinational map from (state, mem_ready) to the datapath control word.
// Built with or without the JUMP state depending on CU_JUMP_EN.
module cu_out_decode
  import cu_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control outputs; anything not set stays 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRC_B_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PC_SRC_ALU;
        // IR load and PC+4 only once the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SRC_B_SHIFT;
        ctrl_o.alu_op    = ALU_ADD;
      end
      StMemAddr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      StExecute: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      StRWb: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StAddiWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRC_B_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PC_SRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
`ifdef CU_JUMP_EN
      StJump: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_SRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle MIPS control unit: state register, opcode dispatch and next-state logic.
// Define CU_JUMP_EN to support the j instruction; otherwise opcode 000010 is illegal.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t state_q, state_d;
  // opcode is only valid in DECODE, so remember lw vs sw for MEM_ADDR
  logic   is_store_q, is_store_d;
  ctrl_t  ctrl;

  logic op_lw, op_sw, op_r, op_addi, op_beq, op_legal;

  assign op_lw   = (opcode == OPCODE_W'(LW));
  assign op_sw   = (opcode == OPCODE_W'(SW));
  assign op_r    = (opcode == OPCODE_W'(R_TYPE));
  assign op_addi = (opcode == OPCODE_W'(ADDI));
  assign op_beq  = (opcode == OPCODE_W'(BEQ));

`ifdef CU_JUMP_EN
  logic op_j;
  assign op_j     = (opcode == OPCODE_W'(J));
  assign op_legal = op_lw | op_sw | op_r | op_addi | op_beq | op_j;
`else
  assign op_legal = op_lw | op_sw | op_r | op_addi | op_beq;
`endif

  // Next-state and store-flag capture
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        is_store_d = op_sw;
        state_d    = StFetch;
        if (op_lw || op_sw) state_d = StMemAddr;
        if (op_r)           state_d = StExecute;
        if (op_addi)        state_d = StAddiEx;
        if (op_beq)         state_d = StBranch;
`ifdef CU_JUMP_EN
        if (op_j)           state_d = StJump;
`endif
      end
      StMemAddr:  state_d = is_store_q ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecute:  state_d = StRWb;
      StRWb:      state_d = StFetch;
      StAddiEx:   state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      StBranch:   state_d = StFetch;
`ifdef CU_JUMP_EN
      StJump:     state_d = StFetch;
`endif
      default:    state_d = StIdle;
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  cu_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Drive the control word onto the ports
  always_comb begin
    pc_write      = ctrl.pc_write;
    pc_write_cond = ctrl.pc_write_cond;
    ir_write      = ctrl.ir_write;
    i_or_d        = ctrl.i_or_d;
    mem_read      = ctrl.mem_read;
    mem_write     = ctrl.mem_write;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_dst       = ctrl.reg_dst;
    reg_write     = ctrl.reg_write;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ALU_OP_W'(ctrl.alu_op);
    pc_source     = ctrl.pc_source;
    instr_done    = ctrl.instr_done;
    illegal_op    = (state_q == StDecode) && !op_legal;
  end

endmodule
